// File: rtl/nx_msg_ingress_pkg.sv
// NXConstants: shared message format and ingress defaults for the node mesh.
package NXConstants;
    localparam int MESSAGE_WIDTH = 31;
    typedef logic [MESSAGE_WIDTH-1:0] node_message_t;
    localparam int INGRESS_FIFO_DEPTH = 4;
endpackage

// File: rtl/nx_fifo.sv
// nx_fifo: generic synchronous FIFO with registered storage and occupancy count.
module nx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr, rd;
    logic push_ok, pop_ok;
    assign full    = level == (PW+1)'(DEPTH);
    assign empty   = level == '0;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd];
    // storage is cleared on reset so no stale message is ever presented
    always_ff @(posedge clk) begin
        if (rst) begin
            wr    <= '0;
            rd    <= '0;
            level <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr] <= push_data;
                wr      <= wr + 1'b1;
            end
            if (pop_ok) rd <= rd + 1'b1;
            level <= level + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        end
    end
endmodule

// File: rtl/nx_msg_ingress.sv
// nx_msg_ingress: assembles LSB-first chunks into node messages and queues them for the mesh.
module nx_msg_ingress
    import NXConstants::*;
#(
    parameter int IN_WIDTH   = 8,
    parameter int FIFO_DEPTH = INGRESS_FIFO_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [IN_WIDTH-1:0]          chunk_data_i,
    input  logic                         chunk_valid_i,
    output logic                         chunk_ready_o,
    input  logic                         flush_i,
    output node_message_t                msg_data_o,
    output logic                         msg_valid_o,
    input  logic                         msg_ready_i,
    output logic                         idle_o,
    output logic [$clog2(FIFO_DEPTH):0]  level_o
);
    localparam int CHUNKS = (MESSAGE_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
    localparam int IW     = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
    localparam int LAST_W = MESSAGE_WIDTH - (CHUNKS - 1) * IN_WIDTH;
    logic [IW-1:0] index;
    node_message_t asm_q, word;
    logic full, empty, last, accept, push;
    assign last          = index == IW'(CHUNKS - 1);
    assign chunk_ready_o = !(last && full);
    assign accept        = chunk_valid_i && chunk_ready_o && !flush_i;
    assign push          = accept && last;
    assign msg_valid_o   = !empty;
    // final chunk overlays the top of the assembly word; its excess bits drop off
    always_comb begin
        word = asm_q;
        word[MESSAGE_WIDTH-1 -: LAST_W] = chunk_data_i[LAST_W-1:0];
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            index  <= '0;
            asm_q  <= '0;
            idle_o <= 1'b0;
        end else begin
            idle_o <= index == '0 && level_o == '0;
            if (flush_i) begin
                index <= '0;
                asm_q <= '0;
            end else if (accept) begin
                index <= last ? '0 : index + 1'b1;
                if (!last) asm_q[int'(index)*IN_WIDTH +: IN_WIDTH] <= chunk_data_i;
            end
        end
    end
    nx_fifo #(.WIDTH(MESSAGE_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push),
        .push_data (word),
        .pop       (msg_valid_o && msg_ready_i),
        .head      (msg_data_o),
        .full      (full),
        .empty     (empty),
        .level     (level_o)
    );
endmodule

// File: tb/tb_nx_msg_ingress.sv
// tb_nx_msg_ingress: directed and randomized checks of chunk assembly, queuing, flush and reset.
module tb_nx_msg_ingress;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  chunk_data = '0;
    logic        chunk_valid = 1'b0;
    logic        chunk_ready;
    logic        flush = 1'b0;
    logic [30:0] msg_data;
    logic        msg_valid;
    logic        msg_ready = 1'b0;
    logic        idle;
    logic [2:0]  level;
    int n_assert = 0;
    int n_fail = 0;
    logic [30:0] exp_q [$];

    nx_msg_ingress #(.IN_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .chunk_data_i  (chunk_data),
        .chunk_valid_i (chunk_valid),
        .chunk_ready_o (chunk_ready),
        .flush_i       (flush),
        .msg_data_o    (msg_data),
        .msg_valid_o   (msg_valid),
        .msg_ready_i   (msg_ready),
        .idle_o        (idle),
        .level_o       (level)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // drives one message as four chunks, junk in the discarded top bit of the last one
    task automatic send_msg(input logic [30:0] m, input int gap_max);
        logic [7:0] c;
        logic acc;
        for (int k = 0; k < 4; k++) begin
            chunk_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) tick();
            c = (k == 3) ? {1'($urandom), m[30:24]} : m[8*k +: 8];
            chunk_data  = c;
            chunk_valid = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 200 && !acc; t++) begin
                acc = chunk_ready;
                tick();
            end
            n_assert++;
            if (!acc) begin
                n_fail++;
                $display("FAIL chunk_accept: chunk %0d of %h never accepted, required accepted", k, m);
            end
        end
        chunk_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick();
        n_assert += 5;
        if (chunk_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", chunk_ready); end
        if (msg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", msg_valid); end
        if (msg_data !== 31'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", msg_data); end
        if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        if (idle !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %b want 0", idle); end
        rst = 1'b0;
        tick();
        n_assert++;
        if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle_after: got %b want 1", idle); end
    endtask

    task automatic test_basic;
        logic [7:0] seq [4];
        seq = '{8'h11, 8'h22, 8'h33, 8'hC4};
        msg_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_assert++;
            if (msg_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: chunk %0d got %b want 0", k, msg_valid); end
            chunk_data = seq[k];
            chunk_valid = 1'b1;
            tick();
        end
        chunk_valid = 1'b0;
        n_assert += 2;
        if (msg_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", msg_valid); end
        if (msg_data !== 31'h44332211) begin n_fail++; $display("FAIL basic_data: got %h want 44332211", msg_data); end
        tick();
        n_assert++;
        if (msg_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got %b want 0", msg_valid); end
        tick();
        n_assert++;
        if (idle !== 1'b1) begin n_fail++; $display("FAIL basic_idle: got %b want 1", idle); end
    endtask

    task automatic test_backpressure;
        logic [30:0] m [5];
        logic acc;
        int j;
        m = '{31'h01020304, 31'h11121314, 31'h21222324, 31'h31323334, 31'h41424344};
        msg_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_msg(m[i], 0);
        n_assert++;
        if (level !== 3'd4) begin n_fail++; $display("FAIL bp_level_full: got %0d want 4", level); end
        for (int k = 0; k < 3; k++) begin
            n_assert++;
            if (chunk_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_nonfinal: chunk %0d got %b want 1", k, chunk_ready); end
            chunk_data = m[4][8*k +: 8];
            chunk_valid = 1'b1;
            tick();
        end
        chunk_data = {1'b0, m[4][30:24]};
        for (int s = 0; s < 3; s++) begin
            n_assert += 2;
            if (chunk_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_stall: got %b want 0", chunk_ready); end
            if (msg_data !== m[0]) begin n_fail++; $display("FAIL bp_data_stable: got %h want %h", msg_data, m[0]); end
            tick();
        end
        msg_ready = 1'b1;
        n_assert++;
        if (chunk_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_excludes_pop: got %b want 0", chunk_ready); end
        j = 0;
        for (int c = 0; c < 40 && j < 5; c++) begin
            acc = chunk_valid && chunk_ready;
            if (msg_valid) begin
                n_assert++;
                if (msg_data !== m[j]) begin n_fail++; $display("FAIL bp_order: msg %0d got %h want %h", j, msg_data, m[j]); end
                j++;
            end
            tick();
            if (acc) chunk_valid = 1'b0;
        end
        chunk_valid = 1'b0;
        n_assert += 2;
        if (j !== 5) begin n_fail++; $display("FAIL bp_count: got %0d want 5", j); end
        if (level !== 3'd0) begin n_fail++; $display("FAIL bp_drained: got %0d want 0", level); end
    endtask

    task automatic test_push_pop_full;
        logic [30:0] p [5];
        p = '{31'h0A000001, 31'h0B000002, 31'h0C000003, 31'h0D000004, 31'h0E000005};
        msg_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_msg(p[i], 1);
        for (int k = 0; k < 3; k++) begin
            chunk_data = p[4][8*k +: 8];
            chunk_valid = 1'b1;
            tick();
        end
        chunk_data = {1'b0, p[4][30:24]};
        msg_ready = 1'b1;
        n_assert += 2;
        if (chunk_ready !== 1'b0) begin n_fail++; $display("FAIL ppf_stall: got %b want 0", chunk_ready); end
        if (msg_data !== p[0]) begin n_fail++; $display("FAIL ppf_head: got %h want %h", msg_data, p[0]); end
        tick();
        msg_ready = 1'b0;
        n_assert += 2;
        if (level !== 3'd3) begin n_fail++; $display("FAIL ppf_level_pop: got %0d want 3", level); end
        if (chunk_ready !== 1'b1) begin n_fail++; $display("FAIL ppf_ready_after: got %b want 1", chunk_ready); end
        tick();
        chunk_valid = 1'b0;
        n_assert++;
        if (level !== 3'd4) begin n_fail++; $display("FAIL ppf_level_push: got %0d want 4", level); end
        msg_ready = 1'b1;
        for (int j = 1; j < 5; j++) begin
            n_assert++;
            if (!msg_valid || msg_data !== p[j]) begin
                n_fail++;
                $display("FAIL ppf_order: msg %0d got valid=%b data=%h want %h", j, msg_valid, msg_data, p[j]);
            end
            tick();
        end
        n_assert++;
        if (level !== 3'd0) begin n_fail++; $display("FAIL ppf_drained: got %0d want 0", level); end
    endtask

    task automatic test_flush;
        msg_ready = 1'b1;
        chunk_valid = 1'b1;
        chunk_data = 8'hAA; tick();
        chunk_data = 8'hBB; tick();
        chunk_valid = 1'b0;
        flush = 1'b1; tick();
        flush = 1'b0;
        chunk_valid = 1'b1;
        chunk_data = 8'h01; tick();
        chunk_data = 8'h02; tick();
        n_assert++;
        if (msg_valid !== 1'b0) begin n_fail++; $display("FAIL flush_index: got valid %b want 0", msg_valid); end
        chunk_data = 8'h03; tick();
        chunk_data = 8'h04; tick();
        chunk_valid = 1'b0;
        n_assert += 2;
        if (msg_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid: got %b want 1", msg_valid); end
        if (msg_data !== 31'h04030201) begin n_fail++; $display("FAIL flush_data: got %h want 04030201", msg_data); end
        tick();
        n_assert++;
        if (msg_valid !== 1'b0) begin n_fail++; $display("FAIL flush_single: got %b want 0", msg_valid); end
        chunk_valid = 1'b1;
        chunk_data = 8'h05; tick();
        chunk_data = 8'h06; tick();
        chunk_data = 8'h07; tick();
        chunk_data = 8'h08;
        flush = 1'b1; tick();
        flush = 1'b0;
        chunk_valid = 1'b0;
        n_assert += 2;
        if (msg_valid !== 1'b0) begin n_fail++; $display("FAIL flush_last_valid: got %b want 0", msg_valid); end
        if (level !== 3'd0) begin n_fail++; $display("FAIL flush_last_level: got %0d want 0", level); end
        tick();
        n_assert++;
        if (idle !== 1'b1) begin n_fail++; $display("FAIL flush_idle: got %b want 1", idle); end
    endtask

    task automatic test_reset_mid;
        msg_ready = 1'b0;
        send_msg(31'h12345678, 0);
        send_msg(31'h2468ACE0, 0);
        chunk_valid = 1'b1;
        chunk_data = 8'h99; tick();
        chunk_data = 8'h88; tick();
        chunk_valid = 1'b0;
        rst = 1'b1; tick();
        rst = 1'b0;
        n_assert += 4;
        if (msg_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", msg_valid); end
        if (level !== 3'd0) begin n_fail++; $display("FAIL rmid_level: got %0d want 0", level); end
        if (chunk_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", chunk_ready); end
        if (msg_data !== 31'h0) begin n_fail++; $display("FAIL rmid_data: got %h want 0", msg_data); end
        msg_ready = 1'b1;
        send_msg(31'h0D0E0F10, 0);
        n_assert += 2;
        if (msg_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_new_valid: got %b want 1", msg_valid); end
        if (msg_data !== 31'h0D0E0F10) begin n_fail++; $display("FAIL rmid_new_data: got %h want 0D0E0F10", msg_data); end
        tick();
    endtask

    task automatic test_random;
        int got = 0;
        logic [30:0] m, e;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    m = 31'($urandom);
                    exp_q.push_back(m);
                    send_msg(m, 2);
                end
            end
            begin
                for (int c = 0; c < 60000 && got < 1000; c++) begin
                    msg_ready = 1'($urandom);
                    if (msg_valid && msg_ready) begin
                        n_assert++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL rand_extra: got %h want no message", msg_data);
                        end else begin
                            e = exp_q.pop_front();
                            if (msg_data !== e) begin n_fail++; $display("FAIL rand_data: msg %0d got %h want %h", got, msg_data, e); end
                        end
                        got++;
                    end
                    tick();
                end
                msg_ready = 1'b0;
            end
        join
        n_assert += 2;
        if (got !== 1000) begin n_fail++; $display("FAIL rand_count: got %0d want 1000", got); end
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rand_leftover: got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_push_pop_full();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
